acc_result_reader: RTL and testbench

Consumer-side reader for the 2N-bit accumulated value register of the filter datapath. It watches the held accumulator word and detects each new value. It rescales each new value from the 2F-fractional product format to the N-bit, F-fractional sample format, with rounding and saturation. Results go into a small FIFO that drains to the downstream consumer (DAC/serializer) over a valid/ready handshake.

---
 rtl/acc_result_reader_if.sv | 12 +
 rtl/acc_result_reader.sv | 103 ++++++++++
 tb/tb_acc_result_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_result_reader_if.sv
// Consumer-side valid/ready channel carrying rescaled samples and their saturation flag.
interface acc_result_reader_if #(
    parameter int N = 25
);
    logic [N-1:0] out_data;
    logic         out_sat;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_data, output out_sat, output out_valid, input out_ready);
    modport slave  (input out_data, input out_sat, input out_valid, output out_ready);
endinterface

// File: rtl/acc_result_reader.sv
// Detects new accumulator values, rescales 2F -> F fractional bits with saturation and queues them.
// Build option: ACC_READER_ROUND_EN adds round-half-up before the shift.
module acc_result_reader #(
    parameter int N     = 25,
    parameter int F     = 15,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [2*N-1:0]         Acumulado_i,
    acc_result_reader_if.master    out_if,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int W  = 2*N + 1;
    localparam logic signed [W-1:0] SAT_MAX = W'((64'sd1 <<< (N-1)) - 64'sd1);
    localparam logic signed [W-1:0] SAT_MIN = W'(-(64'sd1 <<< (N-1)));
`ifdef ACC_READER_ROUND_EN
    localparam logic signed [W-1:0] RND = W'(64'sd1 <<< (F-1));
`endif

    logic [2*N-1:0] last_q;
    logic           primed_q;
    logic           s0_vld_q;
    logic           s1_vld_q;
    logic [N:0]     s1_ent_q, s1_ent_d;
    logic [N:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q, level_d;
    logic           ovf_q;

    logic signed [W-1:0] ext_w, rnd_w, shr_w;
    logic                full, push, pop, drop;
    logic [N:0]          head;

    always_comb begin
        ext_w = signed'({last_q[2*N-1], last_q});
`ifdef ACC_READER_ROUND_EN
        rnd_w = ext_w + RND;
`else
        rnd_w = ext_w;
`endif
        shr_w = rnd_w >>> F;
        if (shr_w > SAT_MAX) begin
            s1_ent_d = {1'b1, SAT_MAX[N-1:0]};
        end else if (shr_w < SAT_MIN) begin
            s1_ent_d = {1'b1, SAT_MIN[N-1:0]};
        end else begin
            s1_ent_d = {1'b0, shr_w[N-1:0]};
        end
    end

    // A pop frees a slot in the same edge, so a full FIFO still accepts the push.
    always_comb begin
        full    = (level_q == LW'(DEPTH));
        head    = mem_q[rd_ptr_q];
        pop     = out_if.out_valid && out_if.out_ready;
        push    = s1_vld_q && (!full || pop);
        drop    = s1_vld_q && !push;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q   <= '0;
            primed_q <= 1'b0;
            s0_vld_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_ent_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            last_q   <= Acumulado_i;
            primed_q <= 1'b1;
            s0_vld_q <= !primed_q || (Acumulado_i != last_q);
            s1_vld_q <= s0_vld_q;
            s1_ent_q <= s1_ent_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q  <= level_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= s1_ent_q;
    end

    assign out_if.out_valid = (level_q != '0);
    assign out_if.out_data  = out_if.out_valid ? head[N-1:0] : '0;
    assign out_if.out_sat   = out_if.out_valid ? head[N]     : 1'b0;
    assign overflow_o       = ovf_q;
    assign level_o          = level_q;
endmodule

// File: tb/tb_acc_result_reader.sv
// Randomised and directed bench for acc_result_reader against a queue-based reference model.
module tb_acc_result_reader;
    localparam int N     = 25;
    localparam int F     = 15;
    localparam int DEPTH = 4;
    localparam int AN    = 2*N;

    logic          clk = 1'b0;
    logic          rst;
    logic [AN-1:0] acc;
    logic          overflow;
    logic [2:0]    level;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int dut_pops = 0;

    acc_result_reader_if #(.N(N)) out_if ();

    acc_result_reader #(.N(N), .F(F), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .Acumulado_i (acc),
        .out_if      (out_if),
        .overflow_o  (overflow),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [N:0] ent;
    } pend_t;

    logic [N:0]    m_fifo [$];
    pend_t         m_pend [$];
    logic          m_primed = 1'b0;
    logic [AN-1:0] m_last   = '0;
    logic          m_ovf    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Divide by 2^F rounding toward -inf, then clamp into the N-bit range.
    function automatic logic [N:0] m_rescale(input logic [AN-1:0] a);
        longint v, q, d, maxv, minv;
        d    = longint'(1) << F;
        maxv = (longint'(1) << (N-1)) - 1;
        minv = -(maxv + 1);
        v    = longint'($signed(a));
`ifdef ACC_READER_ROUND_EN
        v = v + d / 2;
`endif
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        if (q > maxv) q = maxv;
        else if (q < minv) q = minv;
        else return {1'b0, q[N-1:0]};
        return {1'b1, q[N-1:0]};
    endfunction

    task automatic model_edge(input logic [AN-1:0] a, input logic rdy, input logic rs);
        pend_t p;
        cyc++;
        if (rs) begin
            m_fifo.delete();
            m_pend.delete();
            m_ovf    = 1'b0;
            m_primed = 1'b0;
            m_last   = '0;
        end else begin
            if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
            while (m_pend.size() > 0 && m_pend[0].due == cyc) begin
                p = m_pend.pop_front();
                if (m_fifo.size() < DEPTH) m_fifo.push_back(p.ent);
                else m_ovf = 1'b1;
            end
            if (!m_primed || a != m_last) begin
                p.due = cyc + 2;
                p.ent = m_rescale(a);
                m_pend.push_back(p);
            end
            m_last   = a;
            m_primed = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [N:0] e;
        e = (m_fifo.size() > 0) ? m_fifo[0] : '0;
        chk("valid",    64'(out_if.out_valid), 64'(m_fifo.size() > 0));
        chk("data",     64'(out_if.out_data),  64'(e[N-1:0]));
        chk("sat",      64'(out_if.out_sat),   64'(e[N]));
        chk("level",    64'(level),            64'(m_fifo.size()));
        chk("overflow", 64'(overflow),         64'(m_ovf));
    endtask

    task automatic step(input logic [AN-1:0] a, input logic rdy, input logic rs);
        acc = a;
        out_if.out_ready = rdy;
        rst = rs;
        #1;
        if (out_if.out_valid && rdy && !rs) dut_pops++;
        @(posedge clk);
        model_edge(a, rdy, rs);
        #1;
        check_all();
    endtask

    function automatic logic [AN-1:0] pw(input int k);
        return AN'(64'd1 << k);
    endfunction

    task automatic single(input string tag, input logic [AN-1:0] a,
                          input logic [N-1:0] exp_d, input logic exp_s);
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(a, 1'b0, 1'b0);
        chk({tag, "_data"}, 64'(out_if.out_data), 64'(exp_d));
        chk({tag, "_sat"},  64'(out_if.out_sat),  64'(exp_s));
    endtask

    logic [AN-1:0] pool [4];

    initial begin
        rst = 1'b1;
        acc = '0;
        out_if.out_ready = 1'b0;

        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        chk("rst_valid", 64'(out_if.out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);

        // Unity: one result held value, visible after the third sampling edge.
        dut_pops = 0;
        for (int i = 0; i < 10; i++) begin
            step(pw(30), 1'b1, 1'b0);
            if (i == 2) chk("unity_data", 64'(out_if.out_data), 64'd32768);
        end
        chk("unity_count", 64'(dut_pops), 64'd1);

`ifdef ACC_READER_ROUND_EN
        single("round", pw(30) + pw(14), N'(32769), 1'b0);
`else
        single("round", pw(30) + pw(14), N'(32768), 1'b0);
`endif
        single("sat_pos", pw(40), N'(16777215), 1'b1);
        single("sat_neg", AN'(-(64'sd1 <<< 45)), {1'b1, {(N-1){1'b0}}}, 1'b1);
        single("zero_first", '0, '0, 1'b0);

        // Backpressure, then a push coinciding with a pop on a full FIFO.
        step('0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) step(AN'(k) << 15, 1'b0, 1'b0);
        step(AN'(6) << 15, 1'b0, 1'b0);
        step(AN'(6) << 15, 1'b0, 1'b0);
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_ovf",   64'(overflow), 64'd1);
        chk("bp_head",  64'(out_if.out_data), 64'd1);
        step(AN'(7) << 15, 1'b0, 1'b0);
        step(AN'(7) << 15, 1'b0, 1'b0);
        step(AN'(7) << 15, 1'b1, 1'b0);
        chk("full_pp_level", 64'(level), 64'd4);
        chk("full_pp_head",  64'(out_if.out_data), 64'd2);
        for (int i = 0; i < 6; i++) step(AN'(7) << 15, 1'b1, 1'b0);
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_ovf",   64'(overflow), 64'd1);

        // Reset with three queued and two in flight.
        step('0, 1'b0, 1'b1);
        for (int k = 11; k <= 15; k++) step(AN'(k) << 15, 1'b0, 1'b0);
        chk("mid_level_pre", 64'(level), 64'd3);
        step(AN'(15) << 15, 1'b0, 1'b1);
        chk("mid_level", 64'(level), 64'd0);
        chk("mid_valid", 64'(out_if.out_valid), 64'd0);
        chk("mid_ovf",   64'(overflow), 64'd0);
        dut_pops = 0;
        for (int i = 0; i < 8; i++) step(AN'(9) << 15, 1'b1, 1'b0);
        chk("mid_count", 64'(dut_pops), 64'd1);

        // Random traffic: repeats, full-range words, saturating words, random ready and rare resets.
        for (int i = 0; i < 4; i++) pool[i] = AN'({$urandom(), $urandom()});
        for (int i = 0; i < 600; i++) begin
            logic [AN-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = pool[$urandom_range(0, 3)];
                1:       a = AN'({$urandom(), $urandom()});
                2:       a = AN'($signed($urandom_range(0, 65535)) - 32768) << 15;
                default: a = acc;
            endcase
            step(a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
